// File: rtl/vdp_host.sv
// vdp_host: host-side initiator for the vdp99 CPU port. Turns register-write,
// VRAM-write, VRAM-read and status-read requests into spaced wr_tick/rd_tick
// byte transfers, all in the pxclk domain.
// Optional feature macro: VDP_HOST_ADDR_CACHE_EN (VRAM auto-increment pointer
// cache that skips the address setup bytes for sequential accesses).
module vdp_host #(
   parameter int unsigned TICK_GAP = 4
) (
   input  logic        pxclk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [13:0] req_addr,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        wr_tick,
   output logic        rd_tick,
   output logic        mode,
   output logic [7:0]  vdp_din,
   input  logic [7:0]  vdp_dout
);

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 8;
   localparam int unsigned GW = 4;
   localparam logic [GW-1:0] GAP_MAX = GW'(TICK_GAP - 1);

   localparam logic [1:0] OP_REG_WR    = 2'd0;
   localparam logic [1:0] OP_VRAM_WR   = 2'd1;
   localparam logic [1:0] OP_VRAM_RD   = 2'd2;
   localparam logic [1:0] OP_STATUS_RD = 2'd3;

   // States name the byte that is pending; CAPTURE/DONE follow the last tick.
   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP_LO,
      S_SETUP_HI,
      S_ACCESS,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [1:0]      op_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic [GW-1:0]   gap_q;
   logic            wr_tick_q;
   logic            rd_tick_q;
   logic            mode_q;
   logic [DW-1:0]   din_q;
   logic            rsp_valid_q;
   logic [DW-1:0]   rsp_data_q;
   logic            req_ready_q;

   logic            accept;
   logic            gap_ok;
   logic            pending;
   logic            emit;
   logic            cache_hit;
   logic [1:0]      cur_op;
   logic [AW-1:0]   cur_addr;
   logic [DW-1:0]   cur_data;
   state_t          step;
   state_t          step_next;
   logic            tick_rd;
   logic            tick_mode;
   logic [DW-1:0]   tick_byte;
   logic [GW-1:0]   gap_d;

   // Decode the pending byte; in IDLE it comes straight from the request so
   // the first tick can leave the cycle after accept.
   always_comb begin
      accept    = req_valid && req_ready_q && !reset;
      gap_ok    = (gap_q >= GAP_MAX);
      cur_op    = op_q;
      cur_addr  = addr_q;
      cur_data  = data_q;
      step      = state_q;
      pending   = 1'b0;
      tick_rd   = 1'b0;
      tick_mode = 1'b1;
      tick_byte = din_q;
      step_next = S_DONE;

      if (state_q == S_IDLE) begin
         cur_op   = req_op;
         cur_addr = req_addr;
         cur_data = req_data;
         step     = (req_op == OP_STATUS_RD || cache_hit) ? S_ACCESS : S_SETUP_LO;
         pending  = accept;
      end else begin
         pending  = (state_q == S_SETUP_LO) || (state_q == S_SETUP_HI) ||
                    (state_q == S_ACCESS);
      end

      case (step)
         S_SETUP_LO: begin
            tick_byte = (cur_op == OP_REG_WR) ? cur_data : cur_addr[7:0];
            step_next = S_SETUP_HI;
         end
         S_SETUP_HI: begin
            if (cur_op == OP_REG_WR) begin
               tick_byte = {5'b10000, cur_addr[2:0]};
            end else if (cur_op == OP_VRAM_WR) begin
               tick_byte = {2'b01, cur_addr[13:8]};
            end else begin
               tick_byte = {2'b00, cur_addr[13:8]};
            end
            step_next = (cur_op == OP_REG_WR) ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            tick_rd   = (cur_op != OP_VRAM_WR);
            tick_mode = (cur_op == OP_STATUS_RD);
            tick_byte = cur_data;
            step_next = (cur_op != OP_VRAM_WR) ? S_CAPTURE : S_DONE;
         end
         default: ;
      endcase

      emit  = pending && gap_ok;
      gap_d = emit ? '0 : (gap_ok ? GAP_MAX : gap_q + GW'(1));
   end

   // Sequencer: request latch, tick generation, gap counter and read capture.
   always_ff @(posedge pxclk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         gap_q       <= GAP_MAX;
         wr_tick_q   <= 1'b0;
         rd_tick_q   <= 1'b0;
         mode_q      <= 1'b0;
         din_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         req_ready_q <= 1'b0;
      end else begin
         wr_tick_q   <= 1'b0;
         rd_tick_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         gap_q       <= gap_d;

         if (accept) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
         end

         if (emit) begin
            mode_q <= tick_mode;
            if (tick_rd) begin
               rd_tick_q <= 1'b1;
            end else begin
               wr_tick_q <= 1'b1;
               din_q     <= tick_byte;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q <= emit ? step_next : step;
               end
            end
            S_SETUP_LO, S_SETUP_HI, S_ACCESS: begin
               if (emit) begin
                  state_q <= step_next;
               end
            end
            S_CAPTURE: begin
               rsp_data_q  <= vdp_dout;
               rsp_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         req_ready_q <= (state_q == S_DONE) || ((state_q == S_IDLE) && !accept);
      end
   end

`ifdef VDP_HOST_ADDR_CACHE_EN
   logic            cache_vld_q;
   logic            cache_rd_q;
   logic [AW-1:0]   cache_addr_q;

   assign cache_hit = cache_vld_q &&
                      ((req_op == OP_VRAM_WR) || (req_op == OP_VRAM_RD)) &&
                      (req_addr == cache_addr_q) &&
                      (cache_rd_q == (req_op == OP_VRAM_RD));

   // Mirror the VDP auto-increment pointer after every VRAM access tick.
   always_ff @(posedge pxclk) begin
      if (reset) begin
         cache_vld_q  <= 1'b0;
         cache_rd_q   <= 1'b0;
         cache_addr_q <= '0;
      end else if (accept && (req_op == OP_REG_WR)) begin
         cache_vld_q  <= 1'b0;
      end else if (emit && (step == S_ACCESS) && (cur_op != OP_STATUS_RD)) begin
         cache_vld_q  <= 1'b1;
         cache_rd_q   <= (cur_op == OP_VRAM_RD);
         cache_addr_q <= cur_addr + AW'(1);
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   // Reset silences strobes and the handshake in the cycle it is raised.
   assign wr_tick   = wr_tick_q & ~reset;
   assign rd_tick   = rd_tick_q & ~reset;
   assign rsp_valid = rsp_valid_q & ~reset;
   assign req_ready = req_ready_q & ~reset;
   assign mode      = mode_q;
   assign vdp_din   = din_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vdp_host.sv
// tb_vdp_host: directed and randomized requests for vdp_host, checked against
// a transaction-level model of the vdp99 host byte protocol and tick spacing.
// Honours VDP_HOST_ADDR_CACHE_EN to predict the pointer-cache behaviour.
module tb_vdp_host;

   localparam int GAP = 4;
`ifdef VDP_HOST_ADDR_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   localparam logic [1:0] OP_REG_WR    = 2'd0;
   localparam logic [1:0] OP_VRAM_WR   = 2'd1;
   localparam logic [1:0] OP_VRAM_RD   = 2'd2;
   localparam logic [1:0] OP_STATUS_RD = 2'd3;

   typedef struct {
      int         cyc;
      bit         rd;
      bit         md;
      logic [7:0] b;
   } tick_t;

   logic        pxclk     = 1'b0;
   logic        reset     = 1'b1;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op    = 2'd0;
   logic [13:0] req_addr  = 14'd0;
   logic [7:0]  req_data  = 8'd0;
   logic [7:0]  vdp_dout  = 8'd0;
   logic        req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        wr_tick;
   logic        rd_tick;
   logic        mode;
   logic [7:0]  vdp_din;

   int          cyc    = 0;
   int          n_pass = 0;
   int          n_chk  = 0;

   // Reference model state: last tick cycle, pointer cache, last read data.
   int          last_tick = -100;
   bit          c_vld     = 1'b0;
   logic [13:0] c_addr    = 14'd0;
   bit          c_rd      = 1'b0;
   logic [7:0]  last_rsp  = 8'd0;

   vdp_host #(.TICK_GAP(GAP)) dut (
      .pxclk     (pxclk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .wr_tick   (wr_tick),
      .rd_tick   (rd_tick),
      .mode      (mode),
      .vdp_din   (vdp_din),
      .vdp_dout  (vdp_dout)
   );

   always #20 pxclk = ~pxclk;

   always @(posedge pxclk) cyc <= cyc + 1;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic tick_t mk(input bit rd, input bit md, input logic [7:0] b);
      tick_t t;
      t.cyc = 0;
      t.rd  = rd;
      t.md  = md;
      t.b   = b;
      return t;
   endfunction

   // Issue one request, predict its tick train and compare what the DUT emits.
   task automatic do_req(input logic [1:0] op, input logic [13:0] addr,
                         input logic [7:0] data, input logic [7:0] rdv);
      tick_t      exp_q[$];
      tick_t      obs_q[$];
      tick_t      t;
      bit         hit;
      bit         both;
      bit         is_rd;
      int         acc;
      int         waited;
      int         ready_cyc;
      int         rsp_n;
      int         rsp_cyc;
      int         first;
      int         last;
      logic [7:0] rsp_val;
      string      pfx;

      pfx   = $sformatf("op%0d@%04h", op, addr);
      hit   = CACHE && (op == OP_VRAM_WR || op == OP_VRAM_RD) && c_vld &&
              (c_addr == addr) && (c_rd == (op == OP_VRAM_RD));
      is_rd = (op == OP_VRAM_RD) || (op == OP_STATUS_RD);

      case (op)
         OP_REG_WR: begin
            exp_q.push_back(mk(1'b0, 1'b1, data));
            exp_q.push_back(mk(1'b0, 1'b1, 8'h80 | {5'd0, addr[2:0]}));
         end
         OP_STATUS_RD: begin
            exp_q.push_back(mk(1'b1, 1'b1, 8'h00));
         end
         default: begin
            if (!hit) begin
               exp_q.push_back(mk(1'b0, 1'b1, addr[7:0]));
               if (op == OP_VRAM_WR) exp_q.push_back(mk(1'b0, 1'b1, 8'h40 | {2'b00, addr[13:8]}));
               else                  exp_q.push_back(mk(1'b0, 1'b1, {2'b00, addr[13:8]}));
            end
            exp_q.push_back(mk(op == OP_VRAM_RD, 1'b0, data));
         end
      endcase

      vdp_dout = ~rdv;
      waited = 0;
      while (!req_ready && waited < 200) begin
         @(negedge pxclk);
         waited++;
      end
      chk({pfx, " ready_before"}, 32'(req_ready), 32'd1);
      if (req_ready !== 1'b1) return;

      req_op    = op;
      req_addr  = addr;
      req_data  = data;
      req_valid = 1'b1;
      acc       = cyc;
      @(posedge pxclk);
      #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_addr  = 14'($urandom);
      req_data  = 8'($urandom);

      first = (acc + 1 > last_tick + GAP) ? acc + 1 : last_tick + GAP;
      foreach (exp_q[i]) exp_q[i].cyc = first + i * GAP;
      last      = exp_q[exp_q.size() - 1].cyc;
      last_tick = last;

      both = 1'b0;
      ready_cyc = -1;
      rsp_n = 0;
      rsp_cyc = -1;
      rsp_val = 8'h00;
      for (int k = 0; k < 200; k++) begin
         @(negedge pxclk);
         if (wr_tick && rd_tick) both = 1'b1;
         if (wr_tick || rd_tick) begin
            t = mk(rd_tick, mode, vdp_din);
            t.cyc = cyc;
            obs_q.push_back(t);
         end
         vdp_dout = rd_tick ? rdv : ~rdv;
         if (rsp_valid) begin
            rsp_n++;
            rsp_cyc = cyc;
            rsp_val = rsp_data;
         end
         if (req_ready) begin
            ready_cyc = cyc;
            break;
         end
      end

      chk({pfx, " tick_onehot"}, 32'(both), 32'd0);
      chk({pfx, " tick_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            chk($sformatf("%s tick%0d_cycle", pfx, i), 32'(obs_q[i].cyc - acc), 32'(exp_q[i].cyc - acc));
            chk($sformatf("%s tick%0d_kind", pfx, i), 32'(obs_q[i].rd), 32'(exp_q[i].rd));
            chk($sformatf("%s tick%0d_mode", pfx, i), 32'(obs_q[i].md), 32'(exp_q[i].md));
            if (!exp_q[i].rd)
               chk($sformatf("%s tick%0d_din", pfx, i), 32'(obs_q[i].b), 32'(exp_q[i].b));
         end
      end

      if (is_rd) begin
         last_rsp = rdv;
         chk({pfx, " rsp_count"}, 32'(rsp_n), 32'd1);
         chk({pfx, " rsp_cycle"}, 32'(rsp_cyc - acc), 32'(last + 1 - acc));
         chk({pfx, " rsp_data"}, 32'(rsp_val), 32'(rdv));
         chk({pfx, " ready_cycle"}, 32'(ready_cyc - acc), 32'(last + 2 - acc));
      end else begin
         chk({pfx, " rsp_count"}, 32'(rsp_n), 32'd0);
         chk({pfx, " ready_cycle"}, 32'(ready_cyc - acc), 32'(last + 1 - acc));
      end
      chk({pfx, " rsp_data_hold"}, 32'(rsp_data), 32'(last_rsp));

      if (op == OP_REG_WR) begin
         c_vld = 1'b0;
      end else if (op != OP_STATUS_RD) begin
         c_vld  = 1'b1;
         c_addr = addr + 14'd1;
         c_rd   = (op == OP_VRAM_RD);
      end
   endtask

   initial begin
      logic [1:0]  op;
      logic [13:0] a;
      int          nt;
      int          nr;
      bit          seen;

      // Reset values
      repeat (3) @(negedge pxclk);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst wr_tick", 32'(wr_tick), 32'd0);
      chk("rst rd_tick", 32'(rd_tick), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst mode", 32'(mode), 32'd0);
      chk("rst vdp_din", 32'(vdp_din), 32'd0);
      chk("rst rsp_data", 32'(rsp_data), 32'd0);
      reset = 1'b0;
      @(negedge pxclk);
      chk("post_rst req_ready", 32'(req_ready), 32'd1);

      // Basic operations
      do_req(OP_REG_WR,    14'h0007, 8'hF4, 8'h00);
      do_req(OP_VRAM_WR,   14'h1234, 8'hAA, 8'h00);
      do_req(OP_VRAM_RD,   14'h0800, 8'h00, 8'h5C);
      do_req(OP_STATUS_RD, 14'h0000, 8'h00, 8'h80);

      // Pointer wrap, and invalidation by a register write
      do_req(OP_VRAM_WR,   14'h3FFF, 8'h01, 8'h00);
      do_req(OP_VRAM_WR,   14'h0000, 8'h02, 8'h00);
      do_req(OP_VRAM_WR,   14'h3FFF, 8'h03, 8'h00);
      do_req(OP_REG_WR,    14'h0001, 8'hE0, 8'h00);
      do_req(OP_VRAM_WR,   14'h0000, 8'h04, 8'h00);

      // Read stream, direction change, status read leaves pointer alone
      do_req(OP_VRAM_RD,   14'h0200, 8'h00, 8'h11);
      do_req(OP_VRAM_RD,   14'h0201, 8'h00, 8'h22);
      do_req(OP_VRAM_WR,   14'h0202, 8'h33, 8'h00);
      do_req(OP_STATUS_RD, 14'h0000, 8'h00, 8'h9F);
      do_req(OP_VRAM_WR,   14'h0203, 8'h55, 8'h00);
      repeat (7) @(negedge pxclk);
      do_req(OP_VRAM_WR,   14'h0204, 8'h66, 8'h00);

      // Randomized traffic, biased toward sequential addresses
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 2) != 0) ? c_addr : 14'($urandom);
         do_req(op, a, 8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 5)) @(negedge pxclk);
      end

      // Reset between the first and second ticks of a request
      do_req(OP_VRAM_WR, 14'h0100, 8'h11, 8'h00);
      chk("abort ready_before", 32'(req_ready), 32'd1);
      req_op    = OP_VRAM_RD;
      req_addr  = 14'h0300;
      req_valid = 1'b1;
      @(posedge pxclk);
      #1;
      req_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge pxclk);
         if (wr_tick) seen = 1'b1;
      end
      chk("abort first_tick_seen", 32'(seen), 32'd1);
      @(negedge pxclk);
      reset = 1'b1;
      nt = 0;
      nr = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge pxclk);
         nt += int'(wr_tick | rd_tick | rsp_valid);
         nr += int'(req_ready);
      end
      chk("abort strobes_in_reset", 32'(nt), 32'd0);
      chk("abort ready_in_reset", 32'(nr), 32'd0);
      reset = 1'b0;
      @(negedge pxclk);
      chk("abort ready_after", 32'(req_ready), 32'd1);
      nt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge pxclk);
         nt += int'(wr_tick | rd_tick | rsp_valid);
      end
      chk("abort strobes_after", 32'(nt), 32'd0);
      chk("abort rsp_data_cleared", 32'(rsp_data), 32'd0);
      c_vld     = 1'b0;
      last_tick = -100;
      last_rsp  = 8'h00;
      do_req(OP_VRAM_WR, 14'h0101, 8'h77, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
